fifo_level_flags: RTL and testbench

Parametrised synchronous single-clock FIFO. It is the successor to the team's basic push/pop FIFO. It adds the following:
- almost-full and almost-empty thresholds
- a fill-level output
- sticky overflow/underflow error flags
- a synchronous clear
- a selectable first-word-fall-through read mode

It sits between producer and consumer modules on the same clock domain, for example a UART or bus buffer in the lab SoC.

---
 rtl/fifo_level_flags.sv | 89 ++++++++
 tb/tb_fifo_level_flags.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_level_flags.sv
// Single-clock FIFO with fill level, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, synchronous flush and an optional
// first-word-fall-through read port.
module fifo_level_flags #(
  parameter int nrOfEntries          = 32,
  parameter int bitWidth             = 8,
  parameter int almostFullThreshold  = 28,
  parameter int almostEmptyThreshold = 4,
  parameter int fallThrough          = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          push,
  input  logic                          pop,
  input  logic [bitWidth-1:0]           pushData,
  output logic [bitWidth-1:0]           popData,
  output logic                          full,
  output logic                          empty,
  output logic                          almostFull,
  output logic                          almostEmpty,
  output logic [$clog2(nrOfEntries):0]  fillLevel,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int PW = $clog2(nrOfEntries);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(nrOfEntries);
  localparam logic [LW-1:0] AF_TH    = LW'(almostFullThreshold);
  localparam logic [LW-1:0] AE_TH    = LW'(almostEmptyThreshold);

  logic [bitWidth-1:0] mem [nrOfEntries];
  logic [PW-1:0]       rdPtr, wrPtr;
  logic                popAcc, pushAcc;

  // Status is decoded purely from the registered fill level, so no
  // request input reaches a status output combinationally.
  assign empty       = (fillLevel == '0);
  assign full        = (fillLevel == LVL_FULL);
  assign almostFull  = (fillLevel >= AF_TH);
  assign almostEmpty = (fillLevel <= AE_TH);

  // A clear swallows any request issued in the same cycle. At full, a pop
  // frees the slot the push needs, so both are taken together.
  assign popAcc  = pop & ~empty & ~clear;
  assign pushAcc = push & (~full | popAcc) & ~clear;

  // Pointers, fill level and sticky error bits.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      fillLevel <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (pushAcc) wrPtr <= wrPtr + PW'(1);
      if (popAcc)  rdPtr <= rdPtr + PW'(1);
      fillLevel <= fillLevel + LW'(pushAcc) - LW'(popAcc);
      if (push && !pushAcc) overflow  <= 1'b1;
      if (pop && empty)     underflow <= 1'b1;
    end
  end

  // Storage array; contents are meaningless after reset so it is not reset.
  always_ff @(posedge clock) begin
    if (pushAcc) mem[wrPtr] <= pushData;
  end

  generate
    if (fallThrough != 0) begin : g_fwft
      // Head word is shown directly; forced to zero while empty so the
      // port reads as idle after reset or clear.
      assign popData = empty ? '0 : mem[rdPtr];
    end else begin : g_reg
      logic [bitWidth-1:0] popReg;
      // Registered read: the head word is captured on the accepting pop
      // edge. When full, this reads the slot before a same-edge push
      // overwrites it. A clear leaves the last read word in place.
      always_ff @(posedge clock) begin
        if (reset)       popReg <= '0;
        else if (popAcc) popReg <= mem[rdPtr];
      end
      assign popData = popReg;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_level_flags.sv
// Scoreboard bench: a queue-based model predicts the state after every edge,
// a separate monitor compares both read-mode instances against it.
module tb_fifo_level_flags;
  localparam int N  = 32;
  localparam int W  = 8;
  localparam int LW = $clog2(N) + 1;
  localparam int AF = 28;
  localparam int AE = 4;

  logic clock = 1'b0;
  logic reset = 1'b1, clear = 1'b0, push = 1'b0, pop = 1'b0;
  logic [W-1:0] pushData = '0;

  logic [W-1:0]  popData0, popData1;
  logic          full0, empty0, af0, ae0, ov0, un0;
  logic          full1, empty1, af1, ae1, ov1, un1;
  logic [LW-1:0] lvl0, lvl1;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  fifo_level_flags #(.nrOfEntries(N), .bitWidth(W), .almostFullThreshold(AF),
                     .almostEmptyThreshold(AE), .fallThrough(0)) u_reg (
    .clock(clock), .reset(reset), .clear(clear), .push(push), .pop(pop),
    .pushData(pushData), .popData(popData0), .full(full0), .empty(empty0),
    .almostFull(af0), .almostEmpty(ae0), .fillLevel(lvl0),
    .overflow(ov0), .underflow(un0));

  fifo_level_flags #(.nrOfEntries(N), .bitWidth(W), .almostFullThreshold(AF),
                     .almostEmptyThreshold(AE), .fallThrough(1)) u_fwft (
    .clock(clock), .reset(reset), .clear(clear), .push(push), .pop(pop),
    .pushData(pushData), .popData(popData1), .full(full1), .empty(empty1),
    .almostFull(af1), .almostEmpty(ae1), .fillLevel(lvl1),
    .overflow(ov1), .underflow(un1));

  typedef struct {
    int       lvl;
    bit       ov;
    bit       un;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    bit       d1v;
  } exp_t;

  exp_t         expq[$];
  logic [W-1:0] mq[$];
  bit           m_ov, m_un;
  logic [W-1:0] m_pd;

  // Reference model: the FIFO is just a queue of words plus two sticky bits.
  task automatic model_step();
    bit   pok, wok;
    exp_t e;
    if (reset) begin
      mq.delete(); m_ov = 0; m_un = 0; m_pd = '0;
    end else if (clear) begin
      mq.delete(); m_ov = 0; m_un = 0;
    end else begin
      pok = pop && (mq.size() > 0);
      wok = push && ((mq.size() < N) || pok);
      if (pop && !pok)  m_un = 1;
      if (push && !wok) m_ov = 1;
      if (pok) m_pd = mq.pop_front();
      if (wok) mq.push_back(pushData);
    end
    e.lvl = mq.size();
    e.ov  = m_ov;
    e.un  = m_un;
    e.d0  = m_pd;
    e.d1v = (mq.size() > 0);
    e.d1  = e.d1v ? mq[0] : '0;
    expq.push_back(e);
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every edge produces one observable state; pop its prediction.
  initial forever begin
    exp_t e;
    @(posedge clock);
    #1;
    if (expq.size() == 0) begin
      checks++; failures++;
      $display("FAIL no_expectation got=0 expected=1 at %0t", $time);
    end else begin
      e = expq.pop_front();
      cmp("reg_level", 32'(lvl0), 32'(e.lvl));
      cmp("reg_full",  32'(full0), 32'(e.lvl == N));
      cmp("reg_empty", 32'(empty0), 32'(e.lvl == 0));
      cmp("reg_afull", 32'(af0), 32'(e.lvl >= AF));
      cmp("reg_aempty",32'(ae0), 32'(e.lvl <= AE));
      cmp("reg_ovf",   32'(ov0), 32'(e.ov));
      cmp("reg_unf",   32'(un0), 32'(e.un));
      cmp("reg_data",  32'(popData0), 32'(e.d0));
      cmp("ft_level",  32'(lvl1), 32'(e.lvl));
      cmp("ft_full",   32'(full1), 32'(e.lvl == N));
      cmp("ft_empty",  32'(empty1), 32'(e.lvl == 0));
      cmp("ft_afull",  32'(af1), 32'(e.lvl >= AF));
      cmp("ft_aempty", 32'(ae1), 32'(e.lvl <= AE));
      cmp("ft_ovf",    32'(ov1), 32'(e.ov));
      cmp("ft_unf",    32'(un1), 32'(e.un));
      if (e.d1v) cmp("ft_data", 32'(popData1), 32'(e.d1));
    end
  end

  task automatic drive(input logic r, input logic c, input logic pu,
                       input logic po, input logic [W-1:0] d);
    @(negedge clock);
    reset = r; clear = c; push = pu; pop = po; pushData = d;
  endtask

  initial begin
    // reset, then fill 1..32
    drive(1, 0, 0, 0, '0);
    drive(1, 0, 0, 0, '0);
    for (int i = 1; i <= N; i++) drive(0, 0, 1, 0, W'(i));
    // dropped push at full, then drain
    drive(0, 0, 1, 0, 8'hAA);
    for (int i = 0; i < N; i++) drive(0, 0, 0, 1, '0);
    drive(0, 0, 0, 0, '0);
    // refill, simultaneous push/pop at full, drain
    for (int i = 1; i <= N; i++) drive(0, 0, 1, 0, W'(i));
    drive(0, 0, 1, 1, 8'h55);
    for (int i = 0; i < N; i++) drive(0, 0, 0, 1, '0);
    // underflow on empty, then push+pop on empty
    drive(0, 0, 0, 1, '0);
    drive(0, 0, 1, 1, 8'h77);
    drive(0, 0, 0, 1, '0);
    // 40 words with interleaved pops, then drain past almost-empty boundary
    for (int i = 0; i < 40; i++) drive(0, 0, 1, i[0], W'(100 + i));
    for (int i = 0; i < 24; i++) drive(0, 0, 0, 1, '0);
    // random traffic with varying bias and rare clears
    for (int blk = 0; blk < 8; blk++) begin
      int pp, po;
      pp = $urandom_range(20, 90);
      po = $urandom_range(20, 90);
      for (int i = 0; i < 50; i++)
        drive(0, ($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < pp),
              ($urandom_range(0, 99) < po), W'($urandom));
    end
    // fall-through sequence from a clean state
    drive(0, 1, 0, 0, '0);
    drive(0, 0, 1, 0, 8'h10);
    drive(0, 0, 1, 0, 8'h20);
    drive(0, 0, 0, 1, '0);
    drive(0, 0, 0, 1, '0);
    // ten stored words, then clear with push and pop held high
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 0, W'(200 + i));
    drive(0, 1, 1, 1, 8'hEE);
    drive(0, 0, 0, 1, '0);
    // reset in the middle of a stream
    for (int i = 0; i < 6; i++) drive(0, 0, 1, i[0], W'(50 + i));
    drive(1, 0, 1, 1, 8'h99);
    drive(0, 0, 0, 0, '0);
    drive(0, 0, 1, 0, 8'h33);
    drive(0, 0, 0, 1, '0);
    drive(0, 0, 0, 0, '0);
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
